// File: rtl/max_pool_ctrl.sv
// Strided max-pooling controller: walks every KHEIGHTxKWIDTH window of a CHW feature map,
// reads it element by element, keeps the signed maximum and writes one result per window.
module max_pool_ctrl #(
  parameter int BITWIDTH    = 8,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3,
  parameter int KWIDTH      = 2,
  parameter int KHEIGHT     = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                rd_en,
  output logic [$clog2(DATAWIDTH*DATAHEIGHT*DATACHANNEL)-1:0] rd_addr,
  input  logic [BITWIDTH-1:0]                                 rd_data,
  output logic                                                wr_en,
  output logic [$clog2((DATAWIDTH/KWIDTH)*(DATAHEIGHT/KHEIGHT)*DATACHANNEL)-1:0] wr_addr,
  output logic [BITWIDTH-1:0]                                 wr_data
);

  localparam int OW  = DATAWIDTH / KWIDTH;
  localparam int OH  = DATAHEIGHT / KHEIGHT;
  localparam int RAW = $clog2(DATAWIDTH*DATAHEIGHT*DATACHANNEL);
  localparam int WAW = $clog2(OW*OH*DATACHANNEL);
  localparam int CW  = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;
  localparam int YW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int XW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int KYW = (KHEIGHT > 1) ? $clog2(KHEIGHT) : 1;
  localparam int KXW = (KWIDTH > 1) ? $clog2(KWIDTH) : 1;

  localparam logic [CW-1:0]  C_MAX  = CW'(DATACHANNEL - 1);
  localparam logic [YW-1:0]  OY_MAX = YW'(OH - 1);
  localparam logic [XW-1:0]  OX_MAX = XW'(OW - 1);
  localparam logic [KYW-1:0] KY_MAX = KYW'(KHEIGHT - 1);
  localparam logic [KXW-1:0] KX_MAX = KXW'(KWIDTH - 1);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]       c;
  logic [YW-1:0]       oy;
  logic [XW-1:0]       ox;
  logic [KYW-1:0]      ky;
  logic [KXW-1:0]      kx;
  logic [BITWIDTH-1:0] acc;
  logic [BITWIDTH-1:0] wr_hold;
  logic                sample_vld;
  logic                sample_first;

  logic kx_last, ky_last, win_last;

  assign kx_last  = (kx == KX_MAX);
  assign ky_last  = (ky == KY_MAX);
  assign win_last = (c == C_MAX) && (oy == OY_MAX) && (ox == OX_MAX);

  assign rd_addr = RAW'(((32'(c) * 32'(DATAHEIGHT) + 32'(oy) * 32'(KHEIGHT) + 32'(ky))
                         * 32'(DATAWIDTH)) + 32'(ox) * 32'(KWIDTH) + 32'(kx));
  assign wr_addr = WAW'((32'(c) * 32'(OH) + 32'(oy)) * 32'(OW) + 32'(ox));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    wr_data  = wr_hold;
    unique case (state)
      IDLE:    if (start) state_nx = READ;
      READ: begin
        rd_en = 1'b1;
        if (kx_last && ky_last) state_nx = CAPTURE;
      end
      CAPTURE: state_nx = WRITE;
      WRITE: begin
        wr_en    = 1'b1;
        wr_data  = acc;
        state_nx = win_last ? DONE : READ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // rd_data lags rd_en by one cycle, so the compare runs on delayed read flags;
  // the last sample of a window lands during CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c            <= '0;
      oy           <= '0;
      ox           <= '0;
      ky           <= '0;
      kx           <= '0;
      acc          <= '0;
      wr_hold      <= '0;
      sample_vld   <= 1'b0;
      sample_first <= 1'b0;
    end else begin
      sample_vld   <= (state == READ);
      sample_first <= (state == READ) && (kx == '0) && (ky == '0);
      if (sample_vld && (sample_first || ($signed(rd_data) > $signed(acc))))
        acc <= rd_data;
      if (state == READ) begin
        if (kx_last) begin
          kx <= '0;
          ky <= ky_last ? '0 : ky + 1'b1;
        end else begin
          kx <= kx + 1'b1;
        end
      end
      if (state == WRITE) begin
        wr_hold <= acc;
        if (ox == OX_MAX) begin
          ox <= '0;
          if (oy == OY_MAX) begin
            oy <= '0;
            c  <= (c == C_MAX) ? '0 : c + 1'b1;
          end else begin
            oy <= oy + 1'b1;
          end
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: three parameterisations share one memory; a timing/arithmetic
// model predicts every output each cycle, and literal values pin the model.
module tb_max_pool_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic [7:0] mem [0:2351];

  // instance A: 4x4x1, B: 5x5x2, C: defaults 28x28x3
  logic       busy_a, done_a, rd_en_a, wr_en_a;
  logic [3:0] rd_addr_a;
  logic [1:0] wr_addr_a;
  logic [7:0] rd_data_a, wr_data_a;

  logic       busy_b, done_b, rd_en_b, wr_en_b;
  logic [5:0] rd_addr_b;
  logic [2:0] wr_addr_b;
  logic [7:0] rd_data_b, wr_data_b;

  logic        busy_c, done_c, rd_en_c, wr_en_c;
  logic [11:0] rd_addr_c;
  logic [9:0]  wr_addr_c;
  logic [7:0]  rd_data_c, wr_data_c;

  max_pool_ctrl #(.DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

  max_pool_ctrl #(.DATAWIDTH(5), .DATAHEIGHT(5), .DATACHANNEL(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

  max_pool_ctrl dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c));

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
    if (rd_en_c) rd_data_c <= mem[rd_addr_c];
  end

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int checks = 0;
  int errors = 0;

  int  act = 0;
  int  g_w = 4, g_h = 4, g_c = 1;
  int  t0 = 0;
  bit  running = 1'b0;
  int  wr_count = 0;
  int  done_idx = 0;
  int  rowcol_bad = 0;
  logic [7:0] cap_d [0:7];
  int  cap_a [0:7];

  logic       o_rd, o_wr, o_dn, o_bz;
  int         o_ra, o_wa;
  logic [7:0] o_wd;

  always_comb begin
    o_rd = 1'b0; o_wr = 1'b0; o_dn = 1'b0; o_bz = 1'b0; o_ra = 0; o_wa = 0; o_wd = '0;
    case (act)
      0: begin
        o_rd = rd_en_a; o_wr = wr_en_a; o_dn = done_a; o_bz = busy_a;
        o_ra = int'(rd_addr_a); o_wa = int'(wr_addr_a); o_wd = wr_data_a;
      end
      1: begin
        o_rd = rd_en_b; o_wr = wr_en_b; o_dn = done_b; o_bz = busy_b;
        o_ra = int'(rd_addr_b); o_wa = int'(wr_addr_b); o_wd = wr_data_b;
      end
      default: begin
        o_rd = rd_en_c; o_wr = wr_en_c; o_dn = done_c; o_bz = busy_c;
        o_ra = int'(rd_addr_c); o_wa = int'(wr_addr_c); o_wd = wr_data_c;
      end
    endcase
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] win_max(input int c, input int oy, input int ox);
    logic signed [7:0] m, v;
    m = mem[(c*g_h + oy*2)*g_w + ox*2];
    for (int ky = 0; ky < 2; ky++)
      for (int kx = 0; kx < 2; kx++) begin
        v = mem[(c*g_h + oy*2 + ky)*g_w + ox*2 + kx];
        if (v > m) m = v;
      end
    return m;
  endfunction

  // Every pass is a train of 6-cycle windows: 4 reads, one capture, one write; done follows.
  always @(negedge clk) begin
    int idx, p, w, ox, oy, c, ow, oh, dd, r, col;
    bit e_bz, e_rd, e_wr, e_dn;
    ow  = g_w / 2;
    oh  = g_h / 2;
    dd  = g_c * ow * oh * 6 + 1;
    idx = running ? (tick - t0 + 1) : 0;
    e_bz = (idx >= 1) && (idx <= dd);
    p  = (idx > 0) ? (idx - 1) % 6 : 0;
    w  = (idx > 0) ? (idx - 1) / 6 : 0;
    ox = w % ow;
    oy = (w / ow) % oh;
    c  = w / (ow * oh);
    e_rd = e_bz && (idx < dd) && (p < 4);
    e_wr = e_bz && (idx < dd) && (p == 5);
    e_dn = (idx == dd);
    chk("busy", int'(o_bz), int'(e_bz));
    chk("rd_en", int'(o_rd), int'(e_rd));
    chk("wr_en", int'(o_wr), int'(e_wr));
    chk("done", int'(o_dn), int'(e_dn));
    if (e_rd && o_rd)
      chk("rd_addr", o_ra, (c*g_h + oy*2 + p/2)*g_w + ox*2 + p%2);
    if (o_rd) begin
      r   = (o_ra % (g_w*g_h)) / g_w;
      col = o_ra % g_w;
      if (r >= oh*2 || col >= ow*2) rowcol_bad++;
    end
    if (e_wr && o_wr) begin
      chk("wr_addr", o_wa, (c*oh + oy)*ow + ox);
      chk("wr_data", int'(o_wd), int'(win_max(c, oy, ox)));
    end
    if (o_wr) begin
      if (wr_count < 8) begin
        cap_d[wr_count] = o_wd;
        cap_a[wr_count] = o_wa;
      end
      wr_count++;
    end
    if (o_dn) done_idx = idx;
    if (act != 0) chk("idle_a", int'(busy_a), 0);
    if (act != 1) chk("idle_b", int'(busy_b), 0);
    if (act != 2) chk("idle_c", int'(busy_c), 0);
  end

  task automatic drive_start(input bit v);
    case (act)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_busy"},    int'(busy_a), 0);
    chk({tag, "_done"},    int'(done_a), 0);
    chk({tag, "_rd_en"},   int'(rd_en_a), 0);
    chk({tag, "_wr_en"},   int'(wr_en_a), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr_a), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr_a), 0);
    chk({tag, "_wr_data"}, int'(wr_data_a), 0);
  endtask

  task automatic run_pass(input int sel, input bit mid, input bit at_done,
                          input bit chain_out, input bit chained_in, input int abort_at);
    int d;
    bit aborted;
    act = sel;
    case (sel)
      0:       begin g_w = 4;  g_h = 4;  g_c = 1; end
      1:       begin g_w = 5;  g_h = 5;  g_c = 2; end
      default: begin g_w = 28; g_h = 28; g_c = 3; end
    endcase
    d = g_c * (g_w/2) * (g_h/2) * 6 + 1;
    if (!chained_in) begin
      @(negedge clk); #1;
    end
    drive_start(1'b1);
    t0 = tick + 1;
    running = 1'b1;
    wr_count = 0;
    done_idx = 0;
    rowcol_bad = 0;
    aborted = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk); #1;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk_zero_a("abort");
        running = 1'b0;
        aborted = 1'b1;
        break;
      end
      drive_start((mid && k == 5) || (at_done && k == d) || (chain_out && k == d + 1));
    end
    if (aborted) begin
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
    end else if (!chain_out) begin
      running = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2352; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero_a("reset");
    chk("reset_busy_b", int'(busy_b), 0);
    chk("reset_busy_c", int'(busy_c), 0);
    rst = 1'b0;

    // 4x4 ramp: maxima are the bottom-right element of each window
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_pass(0, 0, 0, 0, 0, 0);
    chk("ramp_writes", wr_count, 4);
    chk("ramp_done_cycle", done_idx, 25);
    chk("ramp_d0", int'(cap_d[0]), 5);
    chk("ramp_d1", int'(cap_d[1]), 7);
    chk("ramp_d2", int'(cap_d[2]), 13);
    chk("ramp_d3", int'(cap_d[3]), 15);
    chk("ramp_a3", cap_a[3], 3);

    // signed windows: {-128,-3,-7,-100}, a tie {5,9,9,1}, and all-negative {-1,-128,-127,-2}
    mem[0] = 8'h80; mem[1] = 8'hFD; mem[4] = 8'hF9; mem[5] = 8'h9C;
    mem[2] = 8'd5;  mem[3] = 8'd9;  mem[6] = 8'd9;  mem[7] = 8'd1;
    mem[10] = 8'hFF; mem[11] = 8'h80; mem[14] = 8'h81; mem[15] = 8'hFE;
    run_pass(0, 0, 0, 0, 0, 0);
    chk("neg_d0", int'(cap_d[0]), 8'hFD);
    chk("tie_d1", int'(cap_d[1]), 9);
    chk("neg_d3", int'(cap_d[3]), 8'hFF);

    // 5x5x2: last row/column never touched
    for (int i = 0; i < 50; i++) mem[i] = 8'(i*37 + 11);
    run_pass(1, 0, 0, 0, 0, 0);
    chk("odd_writes", wr_count, 8);
    chk("odd_done_cycle", done_idx, 49);
    chk("odd_rowcol", rowcol_bad, 0);

    // start during READ and during DONE is ignored; start held into IDLE chains a second pass
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    run_pass(0, 1, 1, 0, 0, 0);
    chk("ignore_writes", wr_count, 4);
    idle(4);
    run_pass(0, 0, 1, 1, 0, 0);
    chk("chain_first_writes", wr_count, 4);
    run_pass(0, 0, 0, 0, 1, 0);
    chk("chain_second_writes", wr_count, 4);
    chk("chain_second_done", done_idx, 25);

    // reset during window 2's READ, then a clean pass
    run_pass(0, 0, 0, 0, 0, 14);
    chk("abort_writes", wr_count, 2);
    idle(3);
    run_pass(0, 0, 0, 0, 0, 0);
    chk("post_abort_writes", wr_count, 4);
    chk("post_abort_d0", int'(cap_d[0]), 5);
    chk("post_abort_done", done_idx, 25);

    // default geometry with random data
    for (int i = 0; i < 2352; i++) mem[i] = 8'($urandom);
    run_pass(2, 0, 0, 0, 0, 0);
    chk("full_writes", wr_count, 588);
    chk("full_done_cycle", done_idx, 3529);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
